// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle for obi_rr_arbiter.
// Core side: m_req/m_gnt address phase with packed per-master addr/we/be/wdata,
//            one-hot m_rvalid with broadcast m_rdata.
// Memory side: s_req/s_gnt address phase and s_rvalid/s_rdata responses.
// Status: outstanding (granted, not yet responded) and sticky protocol_err.
// Modport master is the arbiter's view, because it serves the cores and masters the
// memory port. Modport slave is the environment's view: the cores plus the memory.
interface obi_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_gnt;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*BeWidth-1:0]    m_be;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_rvalid;
  logic [DATA_WIDTH-1:0]             m_rdata;

  logic                              s_req;
  logic                              s_gnt;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic                              s_we;
  logic [BeWidth-1:0]                s_be;
  logic [DATA_WIDTH-1:0]             s_wdata;
  logic                              s_rvalid;
  logic [DATA_WIDTH-1:0]             s_rdata;

  logic [CntWidth-1:0]               outstanding;
  logic                              protocol_err;

  modport master (
    input  m_req, m_addr, m_we, m_be, m_wdata, s_gnt, s_rvalid, s_rdata,
    output m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata,
    output outstanding, protocol_err
  );

  modport slave (
    output m_req, m_addr, m_we, m_be, m_wdata, s_gnt, s_rvalid, s_rdata,
    input  m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata,
    input  outstanding, protocol_err
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port between NUM_MASTERS masters.
// Ports: clk, rst_n (async, active-low), bus (obi_rr_arbiter_if.master) carrying the
// per-master request/response bundle, the memory-side port and the status outputs.
// Address phase is combinational (zero added latency). An in-order ID FIFO remembers
// which master owns each outstanding transaction so responses can be routed back.
module obi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  obi_rr_arbiter_if.master  bus
);
  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  logic [IdxW-1:0] last_q, last_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] rr_idx;
  logic [IdxW-1:0] cand_idx;
  logic            found;
  logic [IdxW-1:0] sel;
  logic            full;
  logic            hs;
  logic            pop;

  // First requester scanning upward from last_q+1, wrapping.
  always_comb begin
    rr_idx   = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand_idx = IdxW'((32'(last_q) + i) % NUM_MASTERS);
      if (!found && bus.m_req[cand_idx]) begin
        rr_idx = cand_idx;
        found  = 1'b1;
      end
    end
  end

  assign sel  = lock_q ? lock_idx_q : rr_idx;
  assign full = (count_q == CntMax);

  // Gated by rst_n so the memory port sees no request while reset is held.
  assign bus.s_req   = rst_n & bus.m_req[sel] & ~full;
  assign bus.s_addr  = bus.m_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.s_we    = bus.m_we[sel];
  assign bus.s_be    = bus.m_be[32'(sel)*BeW +: BeW];
  assign bus.s_wdata = bus.m_wdata[32'(sel)*DATA_WIDTH +: DATA_WIDTH];

  assign hs  = bus.s_req & bus.s_gnt;
  assign pop = bus.s_rvalid & (count_q != '0);

  always_comb begin
    bus.m_gnt = '0;
    if (hs) bus.m_gnt[sel] = 1'b1;
  end

  always_comb begin
    bus.m_rvalid = '0;
    if (pop) bus.m_rvalid[fifo_q[rd_ptr_q]] = 1'b1;
  end

  assign bus.m_rdata      = bus.s_rdata;
  assign bus.outstanding  = count_q;
  assign bus.protocol_err = err_q;

  always_comb begin
    last_d     = last_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q;

    if (hs) begin
      last_d   = sel;
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end else if (bus.s_req) begin
      // Stalled request: pin the selection until the slave accepts it.
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    if (pop) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;

    if (hs && !pop)      count_d = count_q + 1'b1;
    else if (pop && !hs) count_d = count_q - 1'b1;

    if (bus.s_rvalid && (count_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= IdxW'(NUM_MASTERS - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      if (hs) fifo_q[wr_ptr_q] <= sel;
    end
  end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  obi_rr_arbiter_if #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) bus ();

  obi_rr_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_req    = '0;
    bus.m_addr   = {32'h0000_0200, 32'h0000_0100};
    bus.m_we     = '0;
    bus.m_be     = '1;
    bus.m_wdata  = '0;
    bus.s_gnt    = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding);
    end
    checks++;
    if (bus.protocol_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.protocol_err);
    end
    checks++;
    if (bus.m_gnt !== 2'b00 || bus.m_rvalid !== 2'b00 || bus.s_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt %b rvalid %b s_req %b want 00 00 0",
               bus.m_gnt, bus.m_rvalid, bus.s_req);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick();
    bus.m_req = 2'b01; bus.s_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_gnt !== 2'b01 || bus.s_addr !== 32'h100 || bus.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL single_grant: gnt %b addr %h out %0d want 01 100 0",
               bus.m_gnt, bus.s_addr, bus.outstanding);
    end
    tick();
    bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b01 || bus.m_rdata !== 32'hDEADBEEF || bus.outstanding !== 3'd1)
    begin
      errors++;
      $display("FAIL single_resp: rvalid %b rdata %h out %0d want 01 deadbeef 1",
               bus.m_rvalid, bus.m_rdata, bus.outstanding);
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0 || bus.m_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL single_done: out %0d rvalid %b want 0 00", bus.outstanding, bus.m_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.m_req = 2'b11; bus.s_gnt = 1'b1; bus.s_rvalid = (k > 0);
      @(negedge clk);
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rv  = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      checks++;
      if (bus.m_gnt !== exp_gnt) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.m_gnt, exp_gnt);
      end
      checks++;
      if (bus.m_rvalid !== exp_rv) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, bus.m_rvalid, exp_rv);
      end
    end
    tick();
    bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b10) begin
      errors++; $display("FAIL rr_last_resp: got %b want 10", bus.m_rvalid);
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL rr_drain: got %0d want 0", bus.outstanding);
    end
  endtask

  task automatic test_lock();
    // One m0 transaction first so m1 holds round-robin priority.
    tick();
    bus.m_req = 2'b01; bus.s_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_gnt !== 2'b01) begin
      errors++; $display("FAIL lock_prep_gnt: got %b want 01", bus.m_gnt);
    end
    tick();
    bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    tick();
    bus.s_rvalid = 1'b0;
    bus.m_addr = {32'h0000_0020, 32'h0000_0010};
    bus.m_req = 2'b01;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) bus.m_req = 2'b11;
      @(negedge clk);
      checks++;
      if (bus.s_addr !== 32'h10 || bus.m_gnt !== 2'b00 || bus.s_req !== 1'b1) begin
        errors++;
        $display("FAIL lock_stall[%0d]: addr %h gnt %b s_req %b want 10 00 1",
                 c, bus.s_addr, bus.m_gnt, bus.s_req);
      end
      tick();
    end
    bus.s_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_gnt !== 2'b01 || bus.s_addr !== 32'h10) begin
      errors++;
      $display("FAIL lock_release: gnt %b addr %h want 01 10", bus.m_gnt, bus.s_addr);
    end
    tick();
    bus.m_req = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.m_gnt !== 2'b10 || bus.s_addr !== 32'h20) begin
      errors++;
      $display("FAIL lock_next: gnt %b addr %h want 10 20", bus.m_gnt, bus.s_addr);
    end
    tick();
    bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b01 || bus.outstanding !== 3'd2) begin
      errors++;
      $display("FAIL lock_resp0: rvalid %b out %0d want 01 2", bus.m_rvalid, bus.outstanding);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b10) begin
      errors++; $display("FAIL lock_resp1: got %b want 10", bus.m_rvalid);
    end
    tick();
    bus.s_rvalid = 1'b0;
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.m_req = 2'b01; bus.s_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_gnt !== 2'b01 || bus.outstanding !== 3'(k)) begin
        errors++;
        $display("FAIL full_fill[%0d]: gnt %b out %0d want 01 %0d",
                 k, bus.m_gnt, bus.outstanding, k);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b0 || bus.m_gnt !== 2'b00 || bus.outstanding !== 3'd4) begin
      errors++;
      $display("FAIL full_block: s_req %b gnt %b out %0d want 0 00 4",
               bus.s_req, bus.m_gnt, bus.outstanding);
    end
    tick();
    bus.s_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b01 || bus.s_req !== 1'b0) begin
      errors++;
      $display("FAIL full_bubble: rvalid %b s_req %b want 01 0", bus.m_rvalid, bus.s_req);
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_req !== 1'b1 || bus.m_gnt !== 2'b01 || bus.outstanding !== 3'd3) begin
      errors++;
      $display("FAIL full_reassert: s_req %b gnt %b out %0d want 1 01 3",
               bus.s_req, bus.m_gnt, bus.outstanding);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_rvalid !== 2'b01 || bus.outstanding !== 3'(4 - k)) begin
        errors++;
        $display("FAIL full_drain[%0d]: rvalid %b out %0d want 01 %0d",
                 k, bus.m_rvalid, bus.outstanding, 4 - k);
      end
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL full_empty: got %0d want 0", bus.outstanding);
    end
  endtask

  task automatic test_routing();
    logic [1:0]  req_v [4];
    logic        gnt_v [4];
    logic [1:0]  exp_gnt [4];
    logic [1:0]  exp_rv [4];
    logic [31:0] rd_v [4];
    req_v   = '{2'b01, 2'b10, 2'b01, 2'b00};
    gnt_v   = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b00};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
    rd_v    = '{32'h0, 32'h1, 32'h2, 32'h3};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.m_req = req_v[k]; bus.s_gnt = gnt_v[k];
      bus.s_rvalid = (k > 0); bus.s_rdata = rd_v[k];
      @(negedge clk);
      checks++;
      if (bus.m_gnt !== exp_gnt[k] || bus.m_rvalid !== exp_rv[k]) begin
        errors++;
        $display("FAIL route[%0d]: gnt %b rvalid %b want %b %b",
                 k, bus.m_gnt, bus.m_rvalid, exp_gnt[k], exp_rv[k]);
      end
      checks++;
      if (bus.m_rdata !== rd_v[k] || (k > 0 && bus.outstanding !== 3'd1)) begin
        errors++;
        $display("FAIL route_data[%0d]: rdata %h out %0d want %h 1",
                 k, bus.m_rdata, bus.outstanding, rd_v[k]);
      end
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL route_empty: got %0d want 0", bus.outstanding);
    end
  endtask

  task automatic test_protocol_err();
    tick();
    bus.s_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b00) begin
      errors++; $display("FAIL err_no_rvalid: got %b want 00", bus.m_rvalid);
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL err_set: err %b out %0d want 1 0", bus.protocol_err, bus.outstanding);
    end
    tick();
    bus.m_req = 2'b01; bus.s_gnt = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.outstanding !== 3'd1) begin
      errors++;
      $display("FAIL err_sticky: err %b out %0d want 1 1", bus.protocol_err, bus.outstanding);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.outstanding !== 3'd0 || bus.m_gnt !== 2'b00 || bus.protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_midreset: out %0d gnt %b err %b want 0 00 0",
               bus.outstanding, bus.m_gnt, bus.protocol_err);
    end
    tick();
    rst_n = 1'b1;
    bus.m_req = 2'b00; bus.s_gnt = 1'b0; bus.s_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_rvalid !== 2'b00) begin
      errors++; $display("FAIL err_late_rvalid: got %b want 00", bus.m_rvalid);
    end
    tick();
    bus.s_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1) begin
      errors++; $display("FAIL err_late_set: got %b want 1", bus.protocol_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_routing();
    test_protocol_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI-style memory port (req/gnt address phase, rvalid response phase) between NUM_MASTERS core-side masters, e.g. the instruction and data buses, in front of the AXI bridge in axi_subsystem.
- Arbitrates round-robin and holds the selection stable while the slave stalls.
- Tracks up to MAX_OUTSTANDING in-order transactions and routes each response back to the master that issued it.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the response-routing ID FIFO (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m_req  in  NUM_MASTERS  per-master request
m_gnt  out  NUM_MASTERS  per-master grant (address-phase handshake)
m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i
m_we  in  NUM_MASTERS  write enable
m_be  in  NUM_MASTERS*DATA_WIDTH/8  byte enables
m_wdata  in  NUM_MASTERS*DATA_WIDTH  write data
m_rvalid  out  NUM_MASTERS  one-hot response valid
m_rdata  out  DATA_WIDTH  response data, broadcast to all masters
s_req  out  1  slave request
s_gnt  in  1  slave grant
s_addr  out  ADDR_WIDTH  selected address
s_we  out  1  selected write enable
s_be  out  DATA_WIDTH/8  selected byte enables
s_wdata  out  DATA_WIDTH  selected write data
s_rvalid  in  1  slave response valid (responses arrive in grant order)
s_rdata  in  DATA_WIDTH  slave response data
outstanding  out  $clog2(MAX_OUTSTANDING+1)  transactions granted but not yet responded
protocol_err  out  1  sticky: s_rvalid received with no transaction outstanding

Behaviour:
- State: last_q (index of the last granted master), lock_q/lock_idx_q, ID FIFO (MAX_OUTSTANDING entries of $clog2(NUM_MASTERS) bits), count_q, err_q.
- Reset: last_q=NUM_MASTERS-1, so master 0 has first priority. FIFO empty, count_q=0, lock_q=0, err_q=0. All outputs 0, with s_addr/s_be/s_wdata/m_rdata driven from their selected or input sources.
- Selection (combinational):
  - If lock_q, sel=lock_idx_q.
  - Otherwise sel is the first requesting index scanning last_q+1 upward, wrapping modulo NUM_MASTERS.
- s_req = m_req[sel] & (count_q != MAX_OUTSTANDING). s_addr/s_we/s_be/s_wdata are muxed from sel. Zero added latency.
- Grant: m_gnt[sel] = s_req & s_gnt; all other m_gnt bits are 0.
- Lock:
  - When s_req=1 and s_gnt=0, set lock_q=1 and lock_idx_q=sel. The slave-side address phase then stays stable even if a higher-priority master raises req.
  - Lock clears on the handshake.
  - Masters must hold req until gnt; a masked master never loses an active, ungranted request.
- Handshake (s_req & s_gnt): push sel into the FIFO, last_q<=sel, lock_q<=0.
- Response:
  - s_rvalid with count_q>0: m_rvalid[fifo_head]=1 in the same cycle (combinational), pop the FIFO.
  - m_rdata = s_rdata always.
- s_rvalid with count_q==0: no m_rvalid, no pop, err_q<=1. err_q stays set until reset.
- Push and pop in the same cycle: count_q unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Full (count_q==MAX_OUTSTANDING): s_req forced 0. A pop while full frees a slot only from the next cycle (one-cycle bubble). Lock cannot be active while full.
- outstanding = count_q.
- Reset mid-operation: the FIFO and lock are dropped. A late slave s_rvalid after reset therefore sets protocol_err.

Test Plan:
1. Only m_req[0]=1, addr 0x100, s_gnt=1, s_rvalid one cycle later with 0xDEADBEEF -> m_gnt[0] in the same cycle; m_rvalid=0b01 with m_rdata=0xDEADBEEF next cycle; outstanding 1 then 0.
2. m_req=0b11 held, s_gnt=1, immediate responses, 6 transactions -> grant order 0,1,0,1,0,1.
3. m0 requests addr 0x10 with s_gnt=0 for 3 cycles; m1 raises req in cycle 1 -> s_addr stays 0x10 for all 3 cycles; m0 granted first, m1 on the next cycle.
4. MAX_OUTSTANDING=4, m_req=0b01, no s_rvalid -> 4 grants, then s_req=0 and outstanding=4. One s_rvalid -> m_rvalid[0]; s_req reasserts the following cycle.
5. Grants in order m0, m1, m0; responses 0x1, 0x2, 0x3 -> m_rvalid 0b01/0b10/0b01 with matching m_rdata. A same-cycle push and pop keeps outstanding constant.
6. s_rvalid with outstanding=0 -> m_rvalid=0 and protocol_err=1, which holds until rst_n is asserted low; mid-traffic reset -> outstanding=0 and m_gnt=0 immediately.
